// File: rtl/double_mult_arbiter_if.sv
// Bus bundle between the N requesters, the shared double-precision
// multiplier and the arbiter that sits between them.
`timescale 1ns/1ps
interface double_mult_arbiter_if #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
);
  // requester side
  logic [N*64-1:0] req_a;
  logic [N*64-1:0] req_b;
  logic [N-1:0]    req_stb;
  logic [N-1:0]    req_ack;
  logic [63:0]     resp_z;
  logic [N-1:0]    resp_stb;
  logic [N-1:0]    resp_ack;
  // multiplier side
  logic [63:0]     mul_a;
  logic [63:0]     mul_b;
  logic            mul_a_stb;
  logic            mul_b_stb;
  logic            mul_a_ack;
  logic            mul_b_ack;
  logic [63:0]     mul_z;
  logic            mul_z_stb;
  logic            mul_z_ack;
  logic            mul_rst;
  // status
  logic            busy;
  logic [W-1:0]    grant_id;
  logic [31:0]     op_count;

  // arbiter view
  modport slave (
    input  req_a, req_b, req_stb, resp_ack,
    input  mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    output req_ack, resp_z, resp_stb,
    output mul_a, mul_b, mul_a_stb, mul_b_stb, mul_z_ack, mul_rst,
    output busy, grant_id, op_count
  );

  // environment view: requesters plus the multiplier
  modport master (
    output req_a, req_b, req_stb, resp_ack,
    output mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    input  req_ack, resp_z, resp_stb,
    input  mul_a, mul_b, mul_a_stb, mul_b_stb, mul_z_ack, mul_rst,
    input  busy, grant_id, op_count
  );
endinterface

// File: rtl/double_mult_arbiter.sv
// Round-robin arbiter sharing one stb/ack double multiplier among N
// requesters. One operand pair is in flight at a time; the product is
// returned to the requester that issued it.
`timescale 1ns/1ps
module double_mult_arbiter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  double_mult_arbiter_if.slave bus
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

  state_t       state_q;
  logic [63:0]  op_a_q, op_b_q, resp_z_q;
  logic [N-1:0] req_ack_q, resp_stb_q;
  logic         mul_a_stb_q, mul_b_stb_q, mul_z_ack_q, busy_q;
  logic [W-1:0] ptr_q, grant_q;
  logic [31:0]  op_count_q;
  logic [1:0]   mul_rst_q;

  logic [63:0]  req_a_arr [N];
  logic [63:0]  req_b_arr [N];
  logic [W-1:0] winner_d;
  logic         found_d;

  // unpack the flat operand buses into per-requester words
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign req_a_arr[gi] = bus.req_a[64*gi +: 64];
      assign req_b_arr[gi] = bus.req_b[64*gi +: 64];
    end
  endgenerate

  function automatic logic [N-1:0] onehot(input logic [W-1:0] id);
    logic [N-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // round-robin search: first request strictly after the last winner
  always_comb begin
    logic [W-1:0] idx;
    winner_d = '0;
    found_d  = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(ptr_q) + k) % N);
      if (!found_d && bus.req_stb[idx]) begin
        winner_d = idx;
        found_d  = 1'b1;
      end
    end
  end

  // transaction sequencer: grant, A, B, Z, response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= W'(N - 1);
      grant_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      resp_z_q    <= '0;
      req_ack_q   <= '0;
      resp_stb_q  <= '0;
      mul_a_stb_q <= 1'b0;
      mul_b_stb_q <= 1'b0;
      mul_z_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      req_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            op_a_q      <= req_a_arr[winner_d];
            op_b_q      <= req_b_arr[winner_d];
            grant_q     <= winner_d;
            req_ack_q   <= onehot(winner_d);
            mul_a_stb_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SEND_A;
          end
        end
        SEND_A: begin
          if (mul_a_stb_q && bus.mul_a_ack) begin
            mul_a_stb_q <= 1'b0;
            mul_b_stb_q <= 1'b1;
            state_q     <= SEND_B;
          end
        end
        SEND_B: begin
          if (mul_b_stb_q && bus.mul_b_ack) begin
            mul_b_stb_q <= 1'b0;
            mul_z_ack_q <= 1'b1;
            state_q     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (bus.mul_z_stb && mul_z_ack_q) begin
            resp_z_q    <= bus.mul_z;
            mul_z_ack_q <= 1'b0;
            resp_stb_q  <= onehot(grant_q);
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (resp_stb_q[grant_q] && bus.resp_ack[grant_q]) begin
            resp_stb_q <= '0;
            ptr_q      <= grant_q;
            op_count_q <= op_count_q + 32'd1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // multiplier reset: asserts with rst, releases on the second edge after
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mul_rst_q <= 2'b11;
    else      mul_rst_q <= {mul_rst_q[0], 1'b0};
  end

  assign bus.mul_a     = op_a_q;
  assign bus.mul_b     = op_b_q;
  assign bus.mul_a_stb = mul_a_stb_q;
  assign bus.mul_b_stb = mul_b_stb_q;
  assign bus.mul_z_ack = mul_z_ack_q;
  assign bus.mul_rst   = mul_rst_q[1];
  assign bus.req_ack   = req_ack_q;
  assign bus.resp_stb  = resp_stb_q;
  assign bus.resp_z    = resp_z_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.op_count  = op_count_q;
endmodule

// File: doc/double_mult_arbiter.md
# double_mult_arbiter

Round-robin arbiter that shares one double-precision multiplier (three-channel stb/ack core: operand A, operand B, result Z) between N requesters in the LU-decomposition datapath. It accepts one operand pair at a time, sequences the multiplier's A, B and Z handshakes, and returns the 64-bit product to the requester that issued it. It also generates the multiplier's active-high reset from the block's reset.

## Interface
- N, 4: number of requesters (2..8); id width W = clog2(N), minimum 1.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_a  in  N*64  operand A per requester; slice i is [64*i+63:64*i].
- req_b  in  N*64  operand B per requester; same slicing.
- req_stb  in  N  requester i has a valid operand pair.
- req_ack  out  N  one-hot, single-cycle accept pulse.
- resp_z  out  64  product; valid while any resp_stb bit is high.
- resp_stb  out  N  one-hot result-valid strobe.
- resp_ack  in  N  requester i takes the result.
- mul_a, mul_b  out  64 each  operands to the multiplier.
- mul_a_stb, mul_b_stb  out  1 each  multiplier operand strobes.
- mul_a_ack, mul_b_ack  in  1 each  multiplier operand acks.
- mul_z  in  64  multiplier result.
- mul_z_stb  in  1  multiplier result strobe.
- mul_z_ack  out  1  result ack to the multiplier.
- mul_rst  out  1  active-high reset for the multiplier.
- busy  out  1  high in every state except IDLE.
- grant_id  out  W  id of the current or last granted requester.
- op_count  out  32  completed transactions; wraps 0xFFFFFFFF -> 0.

## Operation
- Transfer rule on every channel: a transfer happens at a clock edge where stb and ack are both 1. The strobing side holds stb and its data stable until that edge.
- FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
- IDLE:
  - If any req_stb bit is set, pick the winner: the first set bit searching upward from ptr+1, wrapping at N-1 -> 0.
  - Latch that requester's req_a/req_b into op_a/op_b and set grant_id to the winner.
  - Set req_ack[winner] for exactly one cycle; go to SEND_A.
- SEND_A: mul_a = op_a, mul_a_stb = 1. On mul_a_stb & mul_a_ack: clear mul_a_stb, go to SEND_B.
- SEND_B: the same handshake with op_b on the B channel, then go to WAIT_Z.
- WAIT_Z: mul_z_ack = 1. On mul_z_stb & mul_z_ack: latch mul_z into resp_z, clear mul_z_ack, go to RESP.
- RESP: resp_stb[grant_id] = 1. On resp_stb[grant_id] & resp_ack[grant_id]:
  - clear resp_stb;
  - set ptr = grant_id;
  - increment op_count;
  - go to IDLE.
- Requests are sampled only in IDLE. req_stb changes in other states have no effect.
- Only one transaction is in flight; the multiplier is never offered a second operand pair before its result is taken.
- The arbiter passes operand and result bits through unchanged: no arithmetic, no special-case handling.

## Timing
- Reset (rst = 0, asynchronous):
  - state = IDLE, ptr = N-1, so requester 0 has first priority;
  - req_ack, resp_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy = 0;
  - resp_z, mul_a, mul_b, op_a, op_b = 0; grant_id = 0; op_count = 0;
  - mul_rst = 1.
- mul_rst:
  - asserts asynchronously with rst;
  - deasserts synchronously at the second rising edge after rst returns to 1 (two-flop release).
- Reset mid-transaction: the transaction is abandoned with no response. mul_rst forces the multiplier back to its idle state as well.
- Latency from the IDLE grant edge:
  - req_ack is high in the following cycle; mul_a_stb is high in that same cycle.
  - Arbiter overhead is 1 cycle each for IDLE, A, B, Z and RESP, plus the multiplier's own latency and the requester's resp_ack delay.
- Simultaneous requests: exactly one grant per IDLE visit. A requester cannot win twice in a row while another requester's req_stb is high.
- req_ack and resp_stb are never high for two requesters at once.
- busy is registered and equals (state != IDLE).

## Test plan
- Single request: requester 0 sends 2.0 × 3.0 (0x4000000000000000, 0x4008000000000000) -> resp_stb[0] with resp_z = 0x4018000000000000; op_count = 1; one req_ack pulse.
- Fairness: all 4 req_stb held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3; op_count = 8.
- Back-pressure: resp_ack[2] held low for 20 cycles -> resp_stb[2] and resp_z stay stable and no new grant occurs; releasing resp_ack completes the transaction and returns the FSM to IDLE.
- Late request: requester 3 raises req_stb while requester 1 is in WAIT_Z -> requester 3 is served next, with operands captured at the next IDLE edge.
- Reset in SEND_B: pull rst low -> all strobes and acks are 0 immediately; mul_rst = 1 until the second edge after release; the next transaction completes correctly.
- Wrap: preload op_count to 0xFFFFFFFF, complete one transaction -> op_count = 0.
